// File: rtl/spawn_pkg.sv
// Shared types and defaults for the spawn timer and other game blocks that
// reuse the 16-bit LFSR.
package spawn_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_e;

    // Galois mask for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form)
    localparam logic [15:0] LFSR_TAPS          = 16'hB400;
    localparam logic [15:0] DEFAULT_LFSR_SEED  = 16'hACE1;
    localparam logic [31:0] DEFAULT_MIN_PERIOD = 32'h0000_1000;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR with a programmable seed; steps once per cycle with en=1.
// A nonzero seed keeps it out of the all-zero lock-up state.
module lfsr16
    import spawn_pkg::*;
#(
    parameter logic [15:0] SEED = DEFAULT_LFSR_SEED
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic [15:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= SEED;
        end else if (en) begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/spawn_timer.sv
// Periodic spawn-request generator: one request per effective period, each
// carrying a pseudo-random lane and an 8-bit sequence id, with overrun counting.
module spawn_timer
    import spawn_pkg::*;
#(
    parameter int                 CNT_W      = 32,
    parameter int                 LANE_W     = 3,
    parameter logic [CNT_W-1:0]   MIN_PERIOD = CNT_W'(DEFAULT_MIN_PERIOD),
    parameter logic [15:0]        LFSR_SEED  = DEFAULT_LFSR_SEED
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [CNT_W-1:0]  gene_time,
    output logic              spawn_valid,
    input  logic              spawn_ready,
    output logic [LANE_W-1:0] spawn_lane,
    output logic [7:0]        spawn_id,
    output logic [7:0]        overrun_cnt,
    output logic              busy,
    output state_e            dbg_state
);

    state_e             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [CNT_W-1:0]   p_eff, p_eff_n;
    logic [CNT_W-1:0]   p_req;
    logic               valid_n;
    logic [LANE_W-1:0]  lane_n;
    logic [7:0]         id_n;
    logic [7:0]         ovr_n;
    logic [15:0]        lfsr_q;
    logic               lfsr_unused;
    logic               wrap;
    logic               xfer;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (enable),
        .q     (lfsr_q)
    );

    assign lfsr_unused = ^lfsr_q[15:LANE_W];

    assign p_req = (gene_time > MIN_PERIOD) ? gene_time : MIN_PERIOD;
    assign wrap  = enable && (state != IDLE) && (cnt == p_eff);
    // Handshake: a request transfers on every edge where spawn_valid && spawn_ready;
    // lane and id are held while valid is high and no transfer has happened.
    assign xfer  = spawn_valid && spawn_ready;

    assign busy      = (state != IDLE);
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            p_eff       <= MIN_PERIOD;
            spawn_valid <= 1'b0;
            spawn_lane  <= '0;
            spawn_id    <= 8'd0;
            overrun_cnt <= 8'd0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            p_eff       <= p_eff_n;
            spawn_valid <= valid_n;
            spawn_lane  <= lane_n;
            spawn_id    <= id_n;
            overrun_cnt <= ovr_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        p_eff_n = p_eff;
        valid_n = spawn_valid;
        lane_n  = spawn_lane;
        id_n    = spawn_id;
        ovr_n   = overrun_cnt;

        case (state)
            IDLE: begin
                if (enable) begin
                    state_n = RUN;
                    cnt_n   = '0;
                    p_eff_n = p_req;
                end
            end

            RUN: begin
                if (wrap) begin
                    cnt_n   = '0;
                    p_eff_n = p_req;
                    state_n = PEND;
                    valid_n = 1'b1;
                    lane_n  = lfsr_q[LANE_W-1:0];
                end else if (enable) begin
                    cnt_n = cnt + 1'b1;
                end
            end

            PEND: begin
                if (xfer) begin
                    id_n    = spawn_id + 8'd1;
                    valid_n = 1'b0;
                    state_n = RUN;
                end
                if (wrap) begin
                    cnt_n   = '0;
                    p_eff_n = p_req;
                    if (xfer) begin
                        // Back-to-back: the finished request is replaced in place
                        valid_n = 1'b1;
                        state_n = PEND;
                        lane_n  = lfsr_q[LANE_W-1:0];
                    end else begin
                        ovr_n = (overrun_cnt == 8'hFF) ? 8'hFF : overrun_cnt + 8'd1;
                    end
                end else if (enable) begin
                    cnt_n = cnt + 1'b1;
                end
            end

            default: begin
                state_n = IDLE;
                valid_n = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_spawn_timer.sv
// Directed bench for spawn_timer with MIN_PERIOD=4: spawning cadence, clamp,
// backpressure/overrun, back-to-back wrap+transfer, pause and async reset.
module tb_spawn_timer;
    import spawn_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [31:0] gene_time;
    logic        spawn_valid;
    logic        spawn_ready;
    logic [2:0]  spawn_lane;
    logic [7:0]  spawn_id;
    logic [7:0]  overrun_cnt;
    logic        busy;
    state_e      dbg_state;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  exp_q[$];

    logic [15:0] m_lfsr;
    logic [15:0] m_prev;

    spawn_timer #(
        .MIN_PERIOD (32'd4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .gene_time   (gene_time),
        .spawn_valid (spawn_valid),
        .spawn_ready (spawn_ready),
        .spawn_lane  (spawn_lane),
        .spawn_id    (spawn_id),
        .overrun_cnt (overrun_cnt),
        .busy        (busy),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference LFSR ----------------
    function automatic logic [15:0] ref_step(input logic [15:0] x);
        logic [15:0] y;
        logic        out_bit;
        out_bit = x[0];
        y = x >> 1;
        if (out_bit) y = y ^ 16'b1011_0100_0000_0000;
        return y;
    endfunction

    // m_prev holds the register value seen by the most recent enabled edge
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_lfsr = 16'hACE1;
            m_prev = 16'hACE1;
        end else if (enable) begin
            m_prev = m_lfsr;
            m_lfsr = ref_step(m_lfsr);
        end
    end

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        enable      = 1'b0;
        spawn_ready = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic wait_valid(input string tag, input int exp_n);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!spawn_valid && n < 40);
        check({tag, "_valid"}, 32'(spawn_valid), 32'd1);
        check({tag, "_delay"}, 32'(n), 32'(exp_n));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [2:0] held_lane;
        logic       stable_ok;

        rst_n       = 1'b0;
        enable      = 1'b0;
        spawn_ready = 1'b0;
        gene_time   = 32'd10;
        tick(2);

        // reset values
        check("rst_valid",   32'(spawn_valid), 32'd0);
        check("rst_lane",    32'(spawn_lane),  32'd0);
        check("rst_id",      32'(spawn_id),    32'd0);
        check("rst_overrun", 32'(overrun_cnt), 32'd0);
        check("rst_busy",    32'(busy),        32'd0);
        check("rst_state",   32'(dbg_state),   32'(IDLE));
        rst_n = 1'b1;
        tick(1);

        // basic spawning: period 10 -> one pulse every 11 cycles
        exp_q = '{8'd0, 8'd1, 8'd2};
        enable      = 1'b1;
        spawn_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_valid("basic", (k == 0) ? 12 : 10);
            check("basic_id",   32'(spawn_id),   32'(exp_q.pop_front()));
            check("basic_lane", 32'(spawn_lane), 32'(m_prev[2:0]));
            tick(1);
            check("basic_pulse", 32'(spawn_valid), 32'd0);
        end
        check("basic_overrun", 32'(overrun_cnt), 32'd0);

        // clamp to MIN_PERIOD and mid-period gene_time change
        do_reset();
        gene_time   = 32'd2;
        enable      = 1'b1;
        spawn_ready = 1'b1;
        wait_valid("clamp0", 6);
        tick(1);
        wait_valid("clamp1", 4);
        gene_time = 32'd7;
        tick(1);
        wait_valid("clamp_cur", 4);
        tick(1);
        wait_valid("clamp_next", 7);

        // backpressure: three wraps while pending, then one transfer
        do_reset();
        gene_time   = 32'd10;
        enable      = 1'b1;
        spawn_ready = 1'b0;
        wait_valid("bp", 12);
        held_lane = spawn_lane;
        check("bp_lane0", 32'(spawn_lane), 32'(m_prev[2:0]));
        stable_ok = 1'b1;
        for (int i = 0; i < 35; i++) begin
            tick(1);
            if (!spawn_valid || spawn_lane !== held_lane || spawn_id !== 8'd0) stable_ok = 1'b0;
        end
        check("bp_stable",  32'(stable_ok),   32'd1);
        check("bp_overrun", 32'(overrun_cnt), 32'd3);
        check("bp_id_held", 32'(spawn_id),    32'd0);
        spawn_ready = 1'b1;
        tick(1);
        check("bp_xfer_valid", 32'(spawn_valid), 32'd0);
        check("bp_xfer_id",    32'(spawn_id),    32'd1);
        check("bp_state_run",  32'(dbg_state),   32'(RUN));

        // wrap and transfer on the same edge
        spawn_ready = 1'b0;
        wait_valid("sim", 8);
        check("sim_id0", 32'(spawn_id), 32'd1);
        tick(10);
        check("sim_hold", 32'(spawn_valid), 32'd1);
        spawn_ready = 1'b1;
        tick(1);
        check("sim_valid",   32'(spawn_valid), 32'd1);
        check("sim_id",      32'(spawn_id),    32'd2);
        check("sim_lane",    32'(spawn_lane),  32'(m_prev[2:0]));
        check("sim_overrun", 32'(overrun_cnt), 32'd3);
        check("sim_state",   32'(dbg_state),   32'(PEND));
        tick(1);
        check("sim_done", 32'(spawn_valid), 32'd0);
        check("sim_id3",  32'(spawn_id),    32'd3);

        // pause at cnt=5
        do_reset();
        gene_time   = 32'd10;
        enable      = 1'b1;
        spawn_ready = 1'b1;
        tick(6);
        check("pause_cnt0", dut.cnt, 32'd5);
        enable = 1'b0;
        held_lane = spawn_lane;
        stable_ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (spawn_valid) stable_ok = 1'b0;
        end
        check("pause_nospawn", 32'(stable_ok),   32'd1);
        check("pause_cnt",     dut.cnt,          32'd5);
        check("pause_lfsr",    32'(dut.lfsr_q),  32'(m_lfsr));
        check("pause_lane",    32'(spawn_lane),  32'(held_lane));
        check("pause_busy",    32'(busy),        32'd1);
        enable = 1'b1;
        wait_valid("resume", 6);
        check("resume_lane", 32'(spawn_lane), 32'(m_prev[2:0]));

        // pending request completes while paused
        spawn_ready = 1'b0;
        enable      = 1'b0;
        tick(3);
        check("pp_hold", 32'(spawn_valid), 32'd1);
        check("pp_id0",  32'(spawn_id),    32'd0);
        spawn_ready = 1'b1;
        tick(1);
        check("pp_valid", 32'(spawn_valid), 32'd0);
        check("pp_id",    32'(spawn_id),    32'd1);
        check("pp_state", 32'(dbg_state),   32'(RUN));
        check("pp_cnt",   dut.cnt,          32'd0);

        // async reset while pending
        spawn_ready = 1'b0;
        enable      = 1'b1;
        wait_valid("rr", 11);
        #2 rst_n = 1'b0;
        #1;
        check("ar_valid",   32'(spawn_valid), 32'd0);
        check("ar_lane",    32'(spawn_lane),  32'd0);
        check("ar_id",      32'(spawn_id),    32'd0);
        check("ar_overrun", 32'(overrun_cnt), 32'd0);
        check("ar_busy",    32'(busy),        32'd0);
        check("ar_state",   32'(dbg_state),   32'(IDLE));
        check("ar_lfsr",    32'(dut.lfsr_q),  32'h0000ACE1);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        check("ar_after", 32'(spawn_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
